// File: rtl/tlb_miss_arb.sv
// ---------------------------------------------------------------------------
// tlb_miss_arb
//
// Shares one page-table walker among NPORT TLB translation ports. Misses are
// granted one at a time in round-robin order. The granted miss is handed to
// the walker over a valid/ready handshake. The walk result is then returned
// to the originating port as a one-cycle TLB update strobe.
//
// Parameters
//   NPORT        number of miss sources (2..8)
//   LOG_PAGESIZE page-offset bits cleared in the address sent to the walker
//   TIMEOUT      walker timeout in cycles (only with TLB_MISS_TIMEOUT_EN)
//   VADDR_W      virtual address width
//   ASID_W       ASID width
//   TLBE_W       TLB entry width
//
// Optional feature macro
//   TLB_MISS_TIMEOUT_EN  when defined, a walk that gets no ptw_done within
//                        TIMEOUT cycles of WAIT completes with a fault and a
//                        zero entry. When undefined, WAIT holds until
//                        ptw_done arrives.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   paging_en         grants are issued only while high
//   miss_v/adr/asid/id per-port miss request; fields are packed, port 0 in
//                     the low slice
//   miss_ack          one-hot pulse when a miss is captured
//   ptw_req/rdy       walk request handshake
//   ptw_adr/asid/id   captured request; the address has its page offset
//                     cleared
//   ptw_done/fault/tlbe walk result, qualified by ptw_done
//   upd_v             one-hot, one-cycle TLB update strobe
//   upd_tlbe/fault/id update payload
//   busy              sequencer is not idle
// ---------------------------------------------------------------------------
module tlb_miss_arb #(
   parameter int NPORT        = 4,
   parameter int LOG_PAGESIZE = 13,
   parameter int TIMEOUT      = 1023,
   parameter int VADDR_W      = 32,
   parameter int ASID_W       = 16,
   parameter int TLBE_W       = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     paging_en,
   input  logic [NPORT-1:0]         miss_v,
   input  logic [NPORT*VADDR_W-1:0] miss_adr,
   input  logic [NPORT*ASID_W-1:0]  miss_asid,
   input  logic [NPORT*8-1:0]       miss_id,
   output logic [NPORT-1:0]         miss_ack,
   output logic                     ptw_req,
   input  logic                     ptw_rdy,
   output logic [VADDR_W-1:0]       ptw_adr,
   output logic [ASID_W-1:0]        ptw_asid,
   output logic [7:0]               ptw_id,
   input  logic                     ptw_done,
   input  logic                     ptw_fault,
   input  logic [TLBE_W-1:0]        ptw_tlbe,
   output logic [NPORT-1:0]         upd_v,
   output logic [TLBE_W-1:0]        upd_tlbe,
   output logic                     upd_fault,
   output logic [7:0]               upd_id,
   output logic                     busy
);

   localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
   localparam logic [VADDR_W-1:0] OFFSET_MASK =
      (VADDR_W'(1) << LOG_PAGESIZE) - VADDR_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_UPD,
      S_HOLD
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [PW-1:0]     rr_ptr;
   logic [PW-1:0]     port_q;
   logic [PW-1:0]     grant_idx;
   logic              grant_any;
   logic              grant;
   logic              walk_end;
   logic              timeout_hit;
   int                cand;
   logic [VADDR_W-1:0] sel_adr;
   logic [ASID_W-1:0]  sel_asid;
   logic [7:0]         sel_id;

   // Round-robin search: start just after the last granted port and wrap,
   // so the most recently served port has the lowest priority.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = 0;
      for (int i = 1; i <= NPORT; i++) begin
         cand = (int'(rr_ptr) + i) % NPORT;
         if (!grant_any && miss_v[cand[PW-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = cand[PW-1:0];
         end
      end
   end

   assign sel_adr  = miss_adr[grant_idx*VADDR_W +: VADDR_W];
   assign sel_asid = miss_asid[grant_idx*ASID_W +: ASID_W];
   assign sel_id   = miss_id[grant_idx*8 +: 8];

   assign grant    = (state == S_IDLE) && paging_en && grant_any;
   assign walk_end = (state == S_WAIT) && (ptw_done || timeout_hit);

`ifdef TLB_MISS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wait_cnt;

   // Counts WAIT cycles; it restarts on every entry into WAIT.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wait_cnt <= '0;
      end else if (state == S_REQ && ptw_rdy) begin
         wait_cnt <= '0;
      end else if (state == S_WAIT) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   // The count is zero in the first WAIT cycle, so TIMEOUT-1 marks the last
   // one. A ptw_done in that same cycle still takes priority.
   assign timeout_hit = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
   // TIMEOUT only matters when the timeout feature is built in.
   if (TIMEOUT > 0) begin : g_timeout_unused
   end
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. REQ ignores paging_en so that a request, once raised,
   // is never withdrawn before the walker accepts it.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (grant) state_nxt = S_REQ;
         S_REQ:   if (ptw_rdy) state_nxt = S_WAIT;
         S_WAIT:  if (walk_end) state_nxt = S_UPD;
         S_UPD:   state_nxt = S_HOLD;
         S_HOLD:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign ptw_req = (state == S_REQ);
   assign busy    = (state != S_IDLE);

   // Request capture at grant, and result capture at the end of the walk.
   // miss_ack and upd_v are one-cycle pulses. The ack fires during REQ; the
   // update fires during UPD.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr    <= PW'(NPORT - 1);
         port_q    <= '0;
         miss_ack  <= '0;
         ptw_adr   <= '0;
         ptw_asid  <= '0;
         ptw_id    <= '0;
         upd_v     <= '0;
         upd_tlbe  <= '0;
         upd_fault <= 1'b0;
         upd_id    <= '0;
      end else begin
         miss_ack <= '0;
         upd_v    <= '0;
         if (grant) begin
            miss_ack <= NPORT'(1) << grant_idx;
            ptw_adr  <= sel_adr & ~OFFSET_MASK;
            ptw_asid <= sel_asid;
            ptw_id   <= sel_id;
            rr_ptr   <= grant_idx;
            port_q   <= grant_idx;
         end
         if (walk_end) begin
            upd_v  <= NPORT'(1) << port_q;
            upd_id <= ptw_id;
            if (ptw_done) begin
               upd_tlbe  <= ptw_tlbe;
               upd_fault <= ptw_fault;
            end else begin
               upd_tlbe  <= '0;
               upd_fault <= 1'b1;
            end
         end
      end
   end

endmodule
